// File: rtl/fir_coef_pkg.sv
// Shared constants for the FIR coefficient loader: FSM encoding, coefficient
// width and the RAM address-width helper.
package fir_coef_pkg;

    localparam int COEF_WIDTH = 16;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_PEND  = 2'd1;
    localparam logic [1:0] ST_WRITE = 2'd2;

    // RAM address is {filter, tap}
    function automatic int coef_addr_width(input int num_filters, input int max_taps);
        return $clog2(num_filters) + $clog2(max_taps);
    endfunction

    localparam int DEF_ADDR_W = coef_addr_width(4, 256);

endpackage

// File: rtl/fir_coef_loader_tap_counter.sv
// Tap index counter for the coefficient loader: wraps at the effective tap
// count, clears synchronously, and pulses filter_loaded on wrap.
module coef_tap_counter #(
    parameter int MAX_TAPS = 256
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        clear,
    input  logic                        advance,
    input  logic [7:0]                  taps_reg,
    output logic [$clog2(MAX_TAPS)-1:0] tap_index,
    output logic [$clog2(MAX_TAPS)-1:0] tap_next,
    output logic                        wrap,
    output logic                        filter_loaded
);

    localparam int TW = $clog2(MAX_TAPS);

    logic [TW-1:0] n_m1;

    always_comb begin
        if (taps_reg == 8'd0 || {1'b0, taps_reg} > 9'(MAX_TAPS))
            n_m1 = TW'(MAX_TAPS - 1);
        else
            n_m1 = TW'(taps_reg - 8'd1);
    end

    // >= rather than == so a taps register shrunk mid-load still wraps
    assign wrap = advance && !clear && (tap_index >= n_m1);

    always_comb begin
        tap_next = tap_index;
        if (clear)
            tap_next = '0;
        else if (advance)
            tap_next = wrap ? '0 : tap_index + TW'(1);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            tap_index     <= '0;
            filter_loaded <= 1'b0;
        end else begin
            tap_index     <= tap_next;
            filter_loaded <= wrap;
        end
    end

endmodule

// File: rtl/fir_coef_loader.sv
// FIR coefficient RAM write engine with one-deep pending buffer and busy
// arbitration. Define FIR_COEF_CHECKSUM_EN to add the coef_checksum output.
//
// state    | meaning
// IDLE     | no coefficient buffered
// PEND     | coefficient buffered, waiting for ram_busy low
// WRITE    | coef_we high this cycle; tap advances at the end
module fir_coef_loader
    import fir_coef_pkg::*;
#(
    parameter int NUM_FILTERS = 4,
    parameter int MAX_TAPS    = 256,
    parameter int COEF_WIDTH  = fir_coef_pkg::COEF_WIDTH
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   coef_wr_stb,
    input  logic [7:0]             coef_wr_lsb_data_reg,
    input  logic [7:0]             coef_wr_msb_data_reg,
    input  logic [7:0]             filter_select_reg,
    input  logic [7:0]             taps_per_filter_reg,
    input  logic                   load_restart,
    input  logic                   ram_busy,
    output logic                   coef_we,
    output logic [coef_addr_width(NUM_FILTERS, MAX_TAPS)-1:0] coef_addr,
    output logic [COEF_WIDTH-1:0]  coef_wdata,
    output logic [$clog2(MAX_TAPS)-1:0] tap_index,
    output logic                   filter_loaded,
    output logic [NUM_FILTERS-1:0] loaded_mask,
    output logic                   overflow,
    output logic                   sel_error,
`ifdef FIR_COEF_CHECKSUM_EN
    output logic [COEF_WIDTH-1:0]  coef_checksum,
`endif
    output logic                   busy
);

    localparam int FW = $clog2(NUM_FILTERS);
    localparam int TW = $clog2(MAX_TAPS);
    localparam int AW = coef_addr_width(NUM_FILTERS, MAX_TAPS);

    logic [1:0]            state;
    logic [7:0]            filt_q;
    logic [AW-1:0]         buf_addr;
    logic [COEF_WIDTH-1:0] buf_data;
    logic                  sel_in_range;
    logic                  strb_ok;
    logic                  fsel_change;
    logic                  advance;
    logic                  capture;
    logic [TW-1:0]         tap_next;
    logic                  wrap;

    assign sel_in_range = {1'b0, filter_select_reg} < 9'(NUM_FILTERS);
    assign strb_ok      = coef_wr_stb && sel_in_range;
    assign fsel_change  = (filter_select_reg != filt_q) || load_restart;
    assign advance      = (state == ST_WRITE);
    assign capture      = strb_ok && (state == ST_IDLE || state == ST_WRITE);

    coef_tap_counter #(.MAX_TAPS(MAX_TAPS)) u_tap_counter (
        .clk           (clk),
        .reset_n       (reset_n),
        .clear         (fsel_change),
        .advance       (advance),
        .taps_reg      (taps_per_filter_reg),
        .tap_index     (tap_index),
        .tap_next      (tap_next),
        .wrap          (wrap),
        .filter_loaded (filter_loaded)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state       <= ST_IDLE;
            filt_q      <= '0;
            buf_addr    <= '0;
            buf_data    <= '0;
            coef_we     <= 1'b0;
            loaded_mask <= '0;
            overflow    <= 1'b0;
            sel_error   <= 1'b0;
        end else begin
            filt_q <= filter_select_reg;
            if (coef_wr_stb && !sel_in_range)
                sel_error <= 1'b1;

            case (state)
                ST_IDLE: begin
                    if (strb_ok)
                        state <= ST_PEND;
                end
                ST_PEND: begin
                    if (coef_wr_stb)
                        overflow <= 1'b1;
                    if (!ram_busy) begin
                        coef_we <= 1'b1;
                        state   <= ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    coef_we <= 1'b0;
                    state   <= strb_ok ? ST_PEND : ST_IDLE;
                end
                default: begin
                    coef_we <= 1'b0;
                    state   <= ST_IDLE;
                end
            endcase

            // tap_next already reflects this edge's advance or restart
            if (capture) begin
                buf_data <= {coef_wr_msb_data_reg, coef_wr_lsb_data_reg};
                buf_addr <= {filter_select_reg[FW-1:0], tap_next};
            end

            if (wrap)
                loaded_mask[buf_addr[AW-1:TW]] <= 1'b1;
            if (fsel_change && sel_in_range)
                loaded_mask[filter_select_reg[FW-1:0]] <= 1'b0;
        end
    end

    assign coef_addr  = buf_addr;
    assign coef_wdata = buf_data;
    assign busy       = (state != ST_IDLE);

`ifdef FIR_COEF_CHECKSUM_EN
    always_ff @(posedge clk) begin
        if (!reset_n)
            coef_checksum <= '0;
        else if (fsel_change)
            coef_checksum <= '0;
        else if (advance)
            coef_checksum <= coef_checksum + buf_data;
    end
`endif

endmodule

// File: tb/tb_fir_coef_loader.sv
// Bench for fir_coef_loader: directed vector table, hand sequences for the
// multi-cycle corners, and a random phase against a transaction-level model.
module tb_fir_coef_loader;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       stb = 1'b0;
    logic [7:0] lsb = '0;
    logic [7:0] msb = '0;
    logic [7:0] fsel = '0;
    logic [7:0] taps = '0;
    logic       restart = 1'b0;
    logic       rbusy = 1'b0;

    logic        coef_we;
    logic [9:0]  coef_addr;
    logic [15:0] coef_wdata;
    logic [7:0]  tap_index;
    logic        filter_loaded;
    logic [3:0]  loaded_mask;
    logic        overflow;
    logic        sel_error;
    logic        busy;
`ifdef FIR_COEF_CHECKSUM_EN
    logic [15:0] coef_checksum;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    fir_coef_loader dut (
        .clk                  (clk),
        .reset_n              (reset_n),
        .coef_wr_stb          (stb),
        .coef_wr_lsb_data_reg (lsb),
        .coef_wr_msb_data_reg (msb),
        .filter_select_reg    (fsel),
        .taps_per_filter_reg  (taps),
        .load_restart         (restart),
        .ram_busy             (rbusy),
        .coef_we              (coef_we),
        .coef_addr            (coef_addr),
        .coef_wdata           (coef_wdata),
        .tap_index            (tap_index),
        .filter_loaded        (filter_loaded),
        .loaded_mask          (loaded_mask),
        .overflow             (overflow),
        .sel_error            (sel_error),
`ifdef FIR_COEF_CHECKSUM_EN
        .coef_checksum        (coef_checksum),
`endif
        .busy                 (busy)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- reference model (transaction level) ----------------
    typedef struct {
        logic [15:0] data;
        int          filt;
        int          tap;
    } wr_t;

    wr_t         pq[$];
    wr_t         cur;
    bit          cur_v = 0;
    int          m_tap = 0;
    bit [3:0]    m_mask = '0;
    bit          m_ovf = 0;
    bit          m_sel = 0;
    bit          m_loaded = 0;
    logic [7:0]  m_prev = '0;
    logic [15:0] m_sum = '0;

    function automatic int eff_n(input logic [7:0] t);
        return (t == 0 || int'(t) > 256) ? 256 : int'(t);
    endfunction

    always @(posedge clk) begin
        bit          s_stb, s_rst, s_busy, s_rs, chg, inr, had_p;
        logic [7:0]  s_fs, s_tp;
        logic [15:0] s_d;
        wr_t         w;
        s_stb = stb; s_rst = reset_n; s_busy = rbusy; s_rs = restart;
        s_fs = fsel; s_tp = taps; s_d = {msb, lsb};
        if (!s_rst) begin
            pq.delete(); cur_v = 0; m_tap = 0; m_mask = '0; m_ovf = 0;
            m_sel = 0; m_loaded = 0; m_prev = '0; m_sum = '0;
        end else begin
            chg = (s_fs != m_prev) || s_rs;
            m_prev = s_fs;
            inr = (s_fs < 8'd4);
            had_p = (pq.size() > 0);
            m_loaded = 0;
            if (s_stb && !inr) m_sel = 1;
            if (cur_v) begin
                cur_v = 0;
                if (!chg) begin
                    m_sum = m_sum + cur.data;
                    if (m_tap >= eff_n(s_tp) - 1) begin
                        m_tap = 0;
                        m_loaded = 1;
                        m_mask[cur.filt] = 1'b1;
                    end else begin
                        m_tap = m_tap + 1;
                    end
                end
            end
            if (chg) begin
                m_tap = 0;
                m_sum = '0;
                if (inr) m_mask[s_fs[1:0]] = 1'b0;
            end
            if (had_p) begin
                if (s_stb) m_ovf = 1;
                if (!s_busy) begin
                    cur = pq.pop_front();
                    cur_v = 1;
                end
            end else if (s_stb && inr) begin
                w.data = s_d; w.filt = int'(s_fs); w.tap = m_tap;
                pq.push_back(w);
            end
        end
        #2;
        chk("m_we", 32'(coef_we), 32'(cur_v));
        if (cur_v) begin
            chk("m_addr", 32'(coef_addr), 32'(cur.filt * 256 + cur.tap));
            chk("m_wdata", 32'(coef_wdata), 32'(cur.data));
        end
        chk("m_tap", 32'(tap_index), 32'(m_tap));
        chk("m_loaded", 32'(filter_loaded), 32'(m_loaded));
        chk("m_mask", 32'(loaded_mask), 32'(m_mask));
        chk("m_ovf", 32'(overflow), 32'(m_ovf));
        chk("m_sel", 32'(sel_error), 32'(m_sel));
        chk("m_busy", 32'(busy), 32'((pq.size() > 0) || cur_v));
`ifdef FIR_COEF_CHECKSUM_EN
        chk("m_sum", 32'(coef_checksum), 32'(m_sum));
`endif
    end

    // ---------------- directed helpers ----------------
    task automatic write_one(input logic [15:0] d, output logic [9:0] addr, output bit loaded);
        bit seen = 0;
        addr = '0;
        stb = 1'b1; {msb, lsb} = d;
        tick();
        stb = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            tick();
            if (coef_we) begin
                seen = 1;
                addr = coef_addr;
            end
        end
        chk("write_seen", 32'(seen), 32'd1);
        tick();
        loaded = filter_loaded;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_we"}, 32'(coef_we), 0);
        chk({tag, "_addr"}, 32'(coef_addr), 0);
        chk({tag, "_wdata"}, 32'(coef_wdata), 0);
        chk({tag, "_tap"}, 32'(tap_index), 0);
        chk({tag, "_loaded"}, 32'(filter_loaded), 0);
        chk({tag, "_mask"}, 32'(loaded_mask), 0);
        chk({tag, "_ovf"}, 32'(overflow), 0);
        chk({tag, "_sel"}, 32'(sel_error), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
    endtask

    typedef struct {
        bit          stb;
        logic [15:0] data;
        bit          exp_we;
        logic [9:0]  exp_addr;
        logic [15:0] exp_wdata;
        logic [7:0]  exp_tap;
        bit          exp_loaded;
        logic [3:0]  exp_mask;
        bit          exp_busy;
    } vec_t;

    vec_t vec[10];

    initial begin
        logic [9:0]  a;
        bit          l;
        logic [15:0] d;
        logic [15:0] sum;
        int          pulses, pulse_at;

        // basic sequence: taps=4, filter=1, strobe every other cycle
        vec[0] = '{1, 16'h1234, 0, 10'h000, 16'h0000, 8'd0, 0, 4'b0000, 1};
        vec[1] = '{0, 16'h0000, 1, 10'h100, 16'h1234, 8'd0, 0, 4'b0000, 1};
        vec[2] = '{1, 16'h5678, 0, 10'h000, 16'h0000, 8'd1, 0, 4'b0000, 1};
        vec[3] = '{0, 16'h0000, 1, 10'h101, 16'h5678, 8'd1, 0, 4'b0000, 1};
        vec[4] = '{1, 16'h9ABC, 0, 10'h000, 16'h0000, 8'd2, 0, 4'b0000, 1};
        vec[5] = '{0, 16'h0000, 1, 10'h102, 16'h9ABC, 8'd2, 0, 4'b0000, 1};
        vec[6] = '{1, 16'hDEF0, 0, 10'h000, 16'h0000, 8'd3, 0, 4'b0000, 1};
        vec[7] = '{0, 16'h0000, 1, 10'h103, 16'hDEF0, 8'd3, 0, 4'b0000, 1};
        vec[8] = '{0, 16'h0000, 0, 10'h000, 16'h0000, 8'd0, 1, 4'b0010, 0};
        vec[9] = '{0, 16'h0000, 0, 10'h000, 16'h0000, 8'd0, 0, 4'b0010, 0};

        reset_n = 1'b0;
        tick(); tick();
        check_all_zero("reset");
        reset_n = 1'b1;
        fsel = 8'd1; taps = 8'd4;
        tick(); tick();

        for (int i = 0; i < 10; i++) begin
            stb = vec[i].stb;
            {msb, lsb} = vec[i].data;
            tick();
            chk("basic_we", 32'(coef_we), 32'(vec[i].exp_we));
            if (vec[i].exp_we) begin
                chk("basic_addr", 32'(coef_addr), 32'(vec[i].exp_addr));
                chk("basic_wdata", 32'(coef_wdata), 32'(vec[i].exp_wdata));
            end
            chk("basic_tap", 32'(tap_index), 32'(vec[i].exp_tap));
            chk("basic_loaded", 32'(filter_loaded), 32'(vec[i].exp_loaded));
            chk("basic_mask", 32'(loaded_mask), 32'(vec[i].exp_mask));
            chk("basic_busy", 32'(busy), 32'(vec[i].exp_busy));
        end
        stb = 1'b0;

        // busy stall: 10 cycles of ram_busy after the strobe
        rbusy = 1'b1; stb = 1'b1; {msb, lsb} = 16'hA5A5;
        tick();
        stb = 1'b0;
        chk("stall_we", 32'(coef_we), 0);
        for (int i = 0; i < 9; i++) begin
            tick();
            chk("stall_we", 32'(coef_we), 0);
        end
        rbusy = 1'b0;
        tick();
        chk("stall_release_we", 32'(coef_we), 1);
        chk("stall_wdata", 32'(coef_wdata), 32'h0000A5A5);
        chk("stall_addr", 32'(coef_addr), 32'h100);
        tick();
        chk("stall_once", 32'(coef_we), 0);
        tick();
        chk("stall_once2", 32'(coef_we), 0);

        // overflow: second strobe while the first is pending
        rbusy = 1'b1; stb = 1'b1; {msb, lsb} = 16'h1111;
        tick();
        {msb, lsb} = 16'h2222;
        tick();
        stb = 1'b0;
        chk("ovf_flag", 32'(overflow), 1);
        rbusy = 1'b0;
        tick();
        chk("ovf_we", 32'(coef_we), 1);
        chk("ovf_wdata", 32'(coef_wdata), 32'h00001111);
        chk("ovf_addr", 32'(coef_addr), 32'h101);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("ovf_no_second", 32'(coef_we), 0);
        end
        chk("ovf_idle", 32'(busy), 0);

        // out-of-range filter, then a filter switch
        fsel = 8'd5;
        tick();
        stb = 1'b1; {msb, lsb} = 16'hBEEF;
        tick();
        stb = 1'b0;
        chk("sel_flag", 32'(sel_error), 1);
        chk("sel_busy", 32'(busy), 0);
        tick();
        chk("sel_no_we", 32'(coef_we), 0);
        fsel = 8'd0;
        tick();
        for (int i = 0; i < 3; i++) begin
            write_one(16'(16'h0A00 + i), a, l);
            chk("f0_addr", 32'(a), 32'(i));
        end
        fsel = 8'd2;
        tick();
        write_one(16'h2020, a, l);
        chk("switch_addr", 32'(a), 32'h200);

        // taps register 0: 256 taps
        taps = 8'd0; restart = 1'b1;
        tick();
        restart = 1'b0;
        sum = '0; pulses = 0; pulse_at = -1;
        for (int i = 0; i < 256; i++) begin
            d = 16'($urandom);
            sum = sum + d;
            write_one(d, a, l);
            if (i == 0 || i == 255) chk("t256_addr", 32'(a), 32'(512 + i));
            if (l) begin
                pulses++;
                pulse_at = i;
            end
        end
        chk("t256_pulses", 32'(pulses), 1);
        chk("t256_pulse_at", 32'(pulse_at), 255);
        chk("t256_tap", 32'(tap_index), 0);
        chk("t256_mask2", 32'(loaded_mask[2]), 1);
`ifdef FIR_COEF_CHECKSUM_EN
        chk("t256_checksum", 32'(coef_checksum), 32'(sum));
`endif

        // reset while a write is pending
        rbusy = 1'b1; stb = 1'b1; {msb, lsb} = 16'h7777;
        tick();
        stb = 1'b0;
        chk("rstp_busy", 32'(busy), 1);
        reset_n = 1'b0;
        tick();
        check_all_zero("rstp");
        reset_n = 1'b1; rbusy = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("rstp_no_we", 32'(coef_we), 0);
        end

        // random phase against the model
        taps = 8'd3;
        for (int c = 0; c < 3000; c++) begin
            reset_n = ($urandom_range(0, 199) != 0);
            stb     = ($urandom_range(0, 99) < 40);
            {msb, lsb} = 16'($urandom);
            rbusy   = ($urandom_range(0, 99) < 30);
            restart = ($urandom_range(0, 99) < 2);
            if ($urandom_range(0, 99) < 3) fsel = 8'($urandom_range(0, 5));
            if ($urandom_range(0, 199) == 0) taps = 8'($urandom_range(0, 8));
            tick();
        end
        stb = 1'b0; restart = 1'b0; rbusy = 1'b0; reset_n = 1'b1;
        tick(); tick();
        #5;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
